// File: rtl/counter_pkg.sv
// Shared types for the multi-phase counter: stepping modes.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

endpackage

// File: rtl/count_step.sv
// Combinational next-state for the base accumulator: next count, bounce direction and event flag.
module count_step
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] incr,
  input  logic             dir,
  input  mode_t            mode,
  output logic [WIDTH-1:0] next_count,
  output logic             next_dir,
  output logic             step_evt
);

  localparam logic [WIDTH-1:0] MaxVal = '1;

  logic [WIDTH:0] sum;

  always_comb begin
    sum        = {1'b0, count} + {1'b0, incr};
    next_count = count;
    next_dir   = 1'b0;
    step_evt   = 1'b0;
    unique case (mode)
      MODE_WRAP: begin
        next_count = sum[WIDTH-1:0];
        step_evt   = sum[WIDTH];
      end
      MODE_SAT: begin
        next_count = sum[WIDTH] ? MaxVal : sum[WIDTH-1:0];
        // Flag only the arrival at MAX, not the cycles spent parked there.
        step_evt   = (next_count == MaxVal) && (count != MaxVal);
      end
      MODE_BOUNCE: begin
        if (!dir) begin
          if (sum[WIDTH]) begin
            next_count = MaxVal;
            next_dir   = 1'b1;
            step_evt   = 1'b1;
          end else begin
            next_count = sum[WIDTH-1:0];
          end
        end else begin
          if (count < incr) begin
            next_count = '0;
            step_evt   = 1'b1;
          end else begin
            next_count = count - incr;
            next_dir   = 1'b1;
          end
        end
      end
      MODE_HOLD: begin
        next_count = count;
      end
      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/multi_phase_counter.sv
// Base accumulator with selectable stepping mode and NUM_CH phase-offset ROM addresses.
module multi_phase_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_val,
  input  logic [WIDTH-1:0]        incr,
  input  logic [NUM_CH*WIDTH-1:0] offset,
  output logic [WIDTH-1:0]        count,
  output logic                    dir,
  output logic [NUM_CH*WIDTH-1:0] ch_addr,
  output logic                    wrap_pulse,
  output logic                    at_limit
);

  localparam logic [WIDTH-1:0] MaxVal = '1;

  mode_t            mode_e;
  logic [WIDTH-1:0] count_q, count_d, step_count;
  logic             dir_q, dir_d, step_dir;
  logic             wrap_pulse_q, wrap_pulse_d, step_evt;

  assign mode_e = mode_t'(mode);

  count_step #(
    .WIDTH (WIDTH)
  ) u_count_step (
    .count      (count_q),
    .incr       (incr),
    .dir        (dir_q),
    .mode       (mode_e),
    .next_count (step_count),
    .next_dir   (step_dir),
    .step_evt   (step_evt)
  );

  always_comb begin
    count_d      = count_q;
    dir_d        = dir_q;
    wrap_pulse_d = 1'b0;
    if (rst) begin
      count_d = '0;
      dir_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
      dir_d   = 1'b0;
    end else if (en) begin
      count_d      = step_count;
      dir_d        = step_dir;
      wrap_pulse_d = step_evt;
    end
  end

  always_ff @(posedge clk) begin
    count_q      <= count_d;
    dir_q        <= dir_d;
    wrap_pulse_q <= wrap_pulse_d;
  end

  assign count      = count_q;
  assign dir        = dir_q;
  assign wrap_pulse = wrap_pulse_q;

  // at_limit follows the live mode input, so it reflects a mode change immediately.
  always_comb begin
    at_limit = 1'b0;
    if (mode_e == MODE_SAT) begin
      at_limit = (count_q == MaxVal);
    end else if (mode_e == MODE_BOUNCE) begin
      at_limit = (count_q == MaxVal) || (count_q == '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_addr[i*WIDTH +: WIDTH] = count_q + offset[i*WIDTH +: WIDTH];
  end

endmodule

// File: tb/tb_multi_phase_counter.sv
// Directed scoreboard bench: the driver queues hand-computed expectations, a monitor checks each edge.
module tb_multi_phase_counter;
  import counter_pkg::*;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NUM_CH = 2;

  typedef struct {
    logic [7:0] count;
    logic       dir;
    logic       pulse;
    logic       at_limit;
    logic [7:0] ch0;
    logic [7:0] ch1;
    int         idx;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [1:0]              mode;
  logic                    load;
  logic [WIDTH-1:0]        load_val;
  logic [WIDTH-1:0]        incr;
  logic [NUM_CH*WIDTH-1:0] offset;
  logic [WIDTH-1:0]        count;
  logic                    dir;
  logic [NUM_CH*WIDTH-1:0] ch_addr;
  logic                    wrap_pulse;
  logic                    at_limit;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;

  multi_phase_counter #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .load       (load),
    .load_val   (load_val),
    .incr       (incr),
    .offset     (offset),
    .count      (count),
    .dir        (dir),
    .ch_addr    (ch_addr),
    .wrap_pulse (wrap_pulse),
    .at_limit   (at_limit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0h, expected %0h", idx, name, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must show after the next edge.
  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic l,
                      input logic [7:0] lv, input logic [7:0] inc,
                      input logic [7:0] ec, input logic ed, input logic ep, input logic el,
                      input logic [7:0] c0, input logic [7:0] c1);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; load = l; load_val = lv; incr = inc;
    n_step++;
    x.count = ec; x.dir = ed; x.pulse = ep; x.at_limit = el;
    x.ch0 = c0; x.ch1 = c1; x.idx = n_step;
    exp_q.push_back(x);
  endtask

  // Monitor: the counter presents a result every edge once something is outstanding.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check("count", x.idx, 32'(count), 32'(x.count));
      check("dir", x.idx, 32'(dir), 32'(x.dir));
      check("wrap_pulse", x.idx, 32'(wrap_pulse), 32'(x.pulse));
      check("at_limit", x.idx, 32'(at_limit), 32'(x.at_limit));
      check("ch_addr0", x.idx, 32'(ch_addr[7:0]), 32'(x.ch0));
      check("ch_addr1", x.idx, 32'(ch_addr[15:8]), 32'(x.ch1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [1:0] W = MODE_WRAP;
  localparam logic [1:0] S = MODE_SAT;
  localparam logic [1:0] B = MODE_BOUNCE;
  localparam logic [1:0] H = MODE_HOLD;

  initial begin
    rst = 1'b1; en = 1'b1; mode = W; load = 1'b1; load_val = 8'h33; incr = 8'h10;
    offset = {8'h80, 8'h00};
    //    rst  en   mode ld   ldval  incr   count  dir  pls  lim  ch0    ch1
    step(1'b1, 1'b1, W, 1'b1, 8'h33, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80);
    step(1'b0, 1'b0, W, 1'b1, 8'hC0, 8'h40, 8'hC0, 1'b0, 1'b0, 1'b0, 8'hC0, 8'h40);
    step(1'b0, 1'b1, W, 1'b0, 8'h00, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h80);
    step(1'b0, 1'b1, W, 1'b0, 8'h00, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 8'h40, 8'hC0);
    step(1'b0, 1'b1, W, 1'b0, 8'h00, 8'h40, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00);
    step(1'b0, 1'b0, S, 1'b1, 8'hF0, 8'h30, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h70);
    step(1'b0, 1'b1, S, 1'b0, 8'h00, 8'h30, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b1, S, 1'b0, 8'h00, 8'h30, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b1, S, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b1, B, 1'b1, 8'h00, 8'h60, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h80);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h60, 8'h60, 1'b0, 1'b0, 1'b0, 8'h60, 8'hE0);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h60, 8'hC0, 1'b0, 1'b0, 1'b0, 8'hC0, 8'h40);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h60, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h60, 8'h9F, 1'b1, 1'b0, 1'b0, 8'h9F, 8'h1F);
    step(1'b0, 1'b0, B, 1'b0, 8'h00, 8'h60, 8'h9F, 1'b1, 1'b0, 1'b0, 8'h9F, 8'h1F);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h60, 8'h3F, 1'b1, 1'b0, 1'b0, 8'h3F, 8'hBF);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h60, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'h80);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h60, 8'h60, 1'b0, 1'b0, 1'b0, 8'h60, 8'hE0);
    step(1'b0, 1'b1, W, 1'b0, 8'h00, 8'h10, 8'h70, 1'b0, 1'b0, 1'b0, 8'h70, 8'hF0);
    step(1'b0, 1'b1, H, 1'b0, 8'h00, 8'h10, 8'h70, 1'b0, 1'b0, 1'b0, 8'h70, 8'hF0);
    step(1'b0, 1'b0, B, 1'b1, 8'hF0, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h70);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h20, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b1, W, 1'b0, 8'h00, 8'h10, 8'h0F, 1'b0, 1'b1, 1'b0, 8'h0F, 8'h8F);
    step(1'b0, 1'b1, W, 1'b1, 8'h55, 8'h10, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 8'hD5);
    step(1'b0, 1'b0, W, 1'b0, 8'h00, 8'h10, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 8'hD5);
    step(1'b0, 1'b0, W, 1'b0, 8'h00, 8'h10, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 8'hD5);
    step(1'b0, 1'b0, W, 1'b0, 8'h00, 8'h10, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 8'hD5);
    step(1'b1, 1'b1, W, 1'b1, 8'h55, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80);
    step(1'b0, 1'b0, W, 1'b1, 8'h90, 8'h10, 8'h90, 1'b0, 1'b0, 1'b0, 8'h90, 8'h10);
    step(1'b0, 1'b0, B, 1'b1, 8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h7F);
    step(1'b0, 1'b1, B, 1'b0, 8'h00, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h7E);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_phase_counter.md
Name: multi_phase_counter

Overview:
Parametrised successor to the lab's step-increment counter. It provides a single base accumulator with a selectable stepping mode (wrap, saturate, bounce/triangle, hold), a synchronous load, and status flags. From the base count it also derives NUM_CH phase-offset addresses for multi-channel ROM lookup. It sits between the control inputs (vbuddy/top-level) and the sine/waveform ROMs of the signal generator.

Parameters:
WIDTH, 8, bit width of the count, increment, load value, offsets and addresses
NUM_CH, 2, number of phase-offset output channels (≥1)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset, highest priority
en  input  1  step enable; low = hold count and dir
mode  input  2  stepping mode (counter_pkg::mode_t)
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
incr  input  WIDTH  unsigned step size
offset  input  NUM_CH*WIDTH  packed per-channel phase offsets; channel i uses bits [i*WIDTH +: WIDTH]
count  output  WIDTH  registered base count
dir  output  1  registered bounce direction (0 = up, 1 = down)
ch_addr  output  NUM_CH*WIDTH  per-channel address; channel i = count + offset_i mod 2^WIDTH
wrap_pulse  output  1  registered one-cycle event flag
at_limit  output  1  high when count == MAX (2^WIDTH-1) in SAT mode, or when count == MAX or 0 in BOUNCE mode

Behaviour:
- Reset values: count=0, dir=0, wrap_pulse=0. at_limit and ch_addr follow combinationally (ch_addr_i = offset_i).
- Priority, per posedge: rst > load > en.
- rst=1: apply the reset values regardless of the other inputs.
- load=1 (no rst): count<=load_val, dir<=0, wrap_pulse<=0. Applies whether or not en is high.
- en=0 (no rst/load): count and dir hold, wrap_pulse<=0.
- en=1, by mode; sum = count + incr computed at WIDTH+1 bits, MAX = 2^WIDTH-1:
  - WRAP (0): count<=sum[WIDTH-1:0]; wrap_pulse<=sum[WIDTH] (carry out).
  - SAT (1): count<=(sum>MAX)?MAX:sum; wrap_pulse<=1 only on the cycle count first reaches MAX from below.
  - BOUNCE (2), dir=0: if sum>MAX then count<=MAX, dir<=1, wrap_pulse<=1; else count<=sum.
  - BOUNCE (2), dir=1: if count<incr then count<=0, dir<=0, wrap_pulse<=1; else count<=count-incr.
  - HOLD (3): count holds, wrap_pulse<=0.
  - In every mode except BOUNCE, dir<=0 on each enabled cycle.
- Latency: count, dir and wrap_pulse update 1 cycle after the inputs are sampled. ch_addr and at_limit are combinational from the registered count (0 added latency).
- incr=0: count is unchanged in all modes; no pulse; no reversal (sum==count never exceeds MAX).
- BOUNCE with count==MAX and dir=0 and incr>0: reverses that cycle; count stays MAX.
- A mode change mid-run takes effect on the next enabled edge; count is not altered by the change itself.
- ch_addr addition wraps mod 2^WIDTH; no saturation.

Decomposition:
- counter_pkg: typedef enum logic [1:0] mode_t {MODE_WRAP=0, MODE_SAT=1, MODE_BOUNCE=2, MODE_HOLD=3}.
- Sub-module count_step (combinational). Inputs: count, incr, dir, mode. Outputs: next_count, next_dir, event.
- multi_phase_counter holds the registers, the load/reset priority, and a generate loop for ch_addr.

Test Plan:
- WIDTH=8. rst=1 with en=1, load=1, incr=0x10 → next edge count=0x00, dir=0, wrap_pulse=0; ch_addr_i=offset_i.
- WRAP, load 0xC0, then incr=0x40, en=1 → count 0x00 with wrap_pulse=1 for exactly one cycle, then 0x40 with wrap_pulse=0.
- SAT, load 0xF0, incr=0x30 → count 0xFF, wrap_pulse=1 once, at_limit=1; further edges stay 0xFF with wrap_pulse=0.
- BOUNCE, count=0, incr=0x60 → 0x60, 0xC0, 0xFF (dir=1, pulse), 0x9F, 0x3F, 0x00 (dir=0, pulse), 0x60.
- Priority: en=1, load=1, load_val=0x55 in WRAP → count=0x55. Then en=0 for 3 cycles → count holds 0x55, no pulse. Then rst=1 together with load=1 → count=0x00.
- NUM_CH=2, offset={0x80,0x00}, count=0x90 → ch_addr0=0x90, ch_addr1=0x10.
